demux_1_to_4: RTL and testbench
===============================

# demux_1_to_4

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart to the 4-to-1 mux in the muxes library. It accepts one WIDTH-bit beat per cycle on a valid/ready input stream and steers it to one of four output streams, selected by `i_sel`. Each output has a single-entry holding register, so a stalled output blocks only beats routed to it. The block sits between one producer and four independent consumers.

## Interface
- `WIDTH`, 32, data width of input and every output.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_data`  in  WIDTH  input beat.
- `i_sel`  in  2  destination index 0..3; sampled with `i_data`.
- `i_valid`  in  1  input beat present.
- `o_ready`  out  1  block can accept the beat currently addressed.
- `o_data0`..`o_data3`  out  WIDTH  output holding registers.
- `o_valid`  out  4  bit k = `o_data`k holds an undelivered beat.
- `i_ready`  in  4  bit k = consumer k accepts this cycle.

## Operation
- Per output k: holding register `o_data`k plus valid flag `o_valid[k]`.
- Destination d = `i_sel` (see Configuration for the alternate source).
- `o_ready` = !`o_valid[d]` || `i_ready[d]`; combinational from `i_sel`, `o_valid`, `i_ready`. It does not depend on `i_valid`.
- Accept when `i_valid` && `o_ready`.
  - On the next edge, `o_data`d <= `i_data` and `o_valid[d]` <= 1.
- Drain when `o_valid[k]` && `i_ready[k]`.
  - On the next edge, `o_valid[k]` <= 0, unless the same cycle also loads k.
- Drain and load of the same k in one cycle: the new beat replaces the old one, `o_valid[k]` stays 1, and the output keeps full throughput.
- While `o_valid[k]` && !`i_ready[k]`, `o_data`k stays stable; stalled outputs are never overwritten.
- Outputs other than d are unaffected by an accept. All four outputs may drain in the same cycle.
- `i_valid` low: no state change except drains.
- `i_ready[k]` while `o_valid[k]`=0: ignored.
- Beat order per output is preserved. No ordering is defined across outputs.

## Timing
- Reset, asynchronous on `i_rst_n` low:
  - `o_valid` = 4'b0000.
  - `o_data0`..`o_data3` = 0.
  - Round-robin pointer = 0.
  - `o_ready` = 1 once reset has taken effect, since all outputs are empty.
- Reset mid-operation discards all held beats immediately. A beat accepted in the cycle reset asserts is lost.
- Latency: a beat accepted at edge N appears with `o_valid` high after edge N.
- Throughput: 1 beat/cycle to any mix of outputs whose consumers keep `i_ready` high.
- Combinational path from `i_ready` to `o_ready`: one AND/OR level plus a 4:1 select. There is no path from `i_valid` to `o_ready`.

## Configuration
- `DEMUX_1_TO_4_RR_EN` undefined: d = `i_sel`, as above.
- `DEMUX_1_TO_4_RR_EN` defined:
  - `i_sel` is ignored. d = internal 2-bit pointer, reset value 0.
  - The pointer increments by 1 on every accept and wraps 3->0. It holds when there is no accept, including when the target is stalled. A blocked target therefore blocks the whole input: head-of-line blocking is intended.
  - `o_ready` uses the pointer in place of `i_sel`.
  - The port list is unchanged; `i_sel` remains present and unused.

## Test plan
- Reset: hold `i_rst_n`=0 with random inputs.
  - Expect `o_valid`=0000, all `o_data`=0, `o_ready`=1.
  - Release, then send `i_data`=0x11, `i_sel`=2, `i_valid`=1 for one cycle, with `i_ready`=1111.
  - Expect `o_valid`=0100 and `o_data2`=0x11 for exactly one cycle.
- Stall: `i_ready`=0000; send 0xA to sel 1, then 0xB to sel 1.
  - Expect the first beat accepted, then `o_ready`=0 on the second with `o_data1` holding 0xA.
  - Raise `i_ready[1]`: expect 0xB accepted in that same cycle and `o_data1`=0xB on the next cycle.
- Isolation: `o_valid[1]` stalled with `i_ready[1]`=0; send 0xC to sel 3.
  - Expect `o_ready`=1, `o_data3`=0xC, and `o_data1` unchanged.
- Throughput: 8 back-to-back beats 0..7 with `i_sel` cycling 0,1,2,3 and `i_ready`=1111.
  - Expect `o_ready` high every cycle and every beat arriving on the correct output one cycle after acceptance.
- Async reset mid-stream: drop `i_rst_n` between edges while `o_valid`=1010.
  - Expect `o_valid`=0000 immediately, before the next edge.
- With `DEMUX_1_TO_4_RR_EN` defined: send 5 beats 0x20..0x24 with `i_sel`=0 and `i_ready`=1111.
  - Expect outputs 0,1,2,3,0 in order.
  - With `i_ready[1]`=0 and output 1 already full: expect `o_ready`=0 and the pointer held at 1.

Source files
------------

// File: rtl/demux_1_to_4.sv
// demux_1_to_4: registered 1-to-4 valid/ready stream demultiplexer.
// One input beat per cycle is steered into one of four single-entry output
// holding registers. A stalled output only blocks beats addressed to it.
// Optional feature macro: DEMUX_1_TO_4_RR_EN
//   undefined : destination comes from i_sel.
//   defined   : destination comes from an internal round-robin pointer that
//               advances on every accept; i_sel is ignored.

module demux_1_to_4 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_sel,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data0,
  output logic [WIDTH-1:0] o_data1,
  output logic [WIDTH-1:0] o_data2,
  output logic [WIDTH-1:0] o_data3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       i_ready
);

  // Destination index for the beat currently on the input.
  logic [1:0]       w_dest;
  // Addressed slot can take a beat (empty, or being drained this cycle).
  logic             w_ready;
  // Input handshake completes this cycle.
  logic             w_accept;
  // Per-output load and drain strobes.
  logic [3:0]       w_load;
  logic [3:0]       w_drain;

  // Holding registers and their valid flags.
  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [0:3];

`ifdef DEMUX_1_TO_4_RR_EN
  // Round-robin pointer; i_sel has no role in this build.
  logic [1:0] r_ptr;
  logic [1:0] w_unused_sel;

  assign w_unused_sel = i_sel;
  assign w_dest       = r_ptr;

  // Advance the pointer only when a beat is actually taken, so a stalled
  // target holds the pointer (deliberate head-of-line blocking).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end
`else
  assign w_dest = i_sel;
`endif

  // Ready depends only on the addressed slot state and its consumer, never
  // on i_valid, so there is no combinational loop through the producer.
  assign w_ready  = ~r_valid[w_dest] | i_ready[w_dest];
  assign w_accept = i_valid & w_ready;
  assign o_ready  = w_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign w_load[gi]  = w_accept && (w_dest == 2'(gi));
      assign w_drain[gi] = r_valid[gi] & i_ready[gi];

      // Valid flag: a load wins over a drain so a same-cycle replace keeps
      // the slot full and the output runs at full throughput.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid[gi] <= 1'b0;
        end else if (w_load[gi]) begin
          r_valid[gi] <= 1'b1;
        end else if (w_drain[gi]) begin
          r_valid[gi] <= 1'b0;
        end
      end

      // Data register only changes on a load; a stalled slot never loads
      // because w_ready is low for it.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_data[gi] <= '0;
        end else if (w_load[gi]) begin
          r_data[gi] <= i_data;
        end
      end
    end
  endgenerate

  assign o_valid = r_valid;
  assign o_data0 = r_data[0];
  assign o_data1 = r_data[1];
  assign o_data2 = r_data[2];
  assign o_data3 = r_data[3];

endmodule

// File: tb/tb_demux_1_to_4.sv
// Directed testbench for demux_1_to_4.
// Inputs are driven on the falling edge; o_ready is sampled just before the
// rising edge and registered outputs 1 time unit after it.

module tb_demux_1_to_4;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic [1:0]       sel;
  logic             valid;
  logic             ready_out;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       valid_out;
  logic [3:0]       cons_ready;

  int errors = 0;
  int checks = 0;

  demux_1_to_4 #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_sel   (sel),
    .i_valid (valid),
    .o_ready (ready_out),
    .o_data0 (d0),
    .o_data1 (d1),
    .o_data2 (d2),
    .o_data3 (d3),
    .o_valid (valid_out),
    .i_ready (cons_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] data_of(input int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = $urandom; sel = 2'($urandom); valid = 1'($urandom);
      cons_ready = 4'($urandom);
    end
    #1;
    checks++;
    if (valid_out !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b want 0000", valid_out);
    end
    checks++;
    if ({d0, d1, d2, d3} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want all 0", d0, d1, d2, d3);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_out);
    end
    @(negedge clk);
    valid = 1'b0; cons_ready = 4'b0000; data = '0; sel = 2'd0;
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_first_beat();
    @(negedge clk);
    data = 32'h11; sel = 2'd2; valid = 1'b1; cons_ready = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 4'b0100 || d2 !== 32'h11) begin
      errors++; $display("FAIL first_beat: got valid=%b d2=%h want 0100/11", valid_out, d2);
    end
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 4'b0000) begin
      errors++; $display("FAIL first_beat_drain: got valid=%b want 0000", valid_out);
    end
    $display("beat 0x11 -> out2, delivered");
  endtask

  task automatic test_stall();
    @(negedge clk);
    cons_ready = 4'b0000; data = 32'hA; sel = 2'd1; valid = 1'b1;
    #4;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL stall_first_ready: got %b want 1", ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 4'b0010 || d1 !== 32'hA) begin
      errors++; $display("FAIL stall_first_load: got valid=%b d1=%h want 0010/a", valid_out, d1);
    end
    @(negedge clk);
    data = 32'hB;
    #4;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++; $display("FAIL stall_blocked_ready: got %b want 0", ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (d1 !== 32'hA || valid_out !== 4'b0010) begin
      errors++; $display("FAIL stall_hold: got valid=%b d1=%h want 0010/a", valid_out, d1);
    end
    @(negedge clk);
    cons_ready = 4'b0010;
    #4;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b want 1", ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (d1 !== 32'hB || valid_out !== 4'b0010) begin
      errors++; $display("FAIL stall_replace: got valid=%b d1=%h want 0010/b", valid_out, d1);
    end
    @(negedge clk);
    valid = 1'b0; cons_ready = 4'b0000;
    $display("beats 0xA,0xB -> out1, second held until consumer ready");
  endtask

  task automatic test_isolation();
    @(negedge clk);
    data = 32'hC; sel = 2'd3; valid = 1'b1; cons_ready = 4'b0000;
    #4;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL iso_ready: got %b want 1", ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (d3 !== 32'hC || d1 !== 32'hB || valid_out !== 4'b1010) begin
      errors++; $display("FAIL iso_data: got valid=%b d1=%h d3=%h want 1010/b/c", valid_out, d1, d3);
    end
    @(negedge clk);
    valid = 1'b0;
    $display("beat 0xC -> out3 while out1 stalled");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    checks++;
    if (valid_out !== 4'b1010) begin
      errors++; $display("FAIL areset_pre: got valid=%b want 1010", valid_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 4'b0000 || d1 !== '0 || d3 !== '0) begin
      errors++; $display("FAIL areset_now: got valid=%b d1=%h d3=%h want 0000/0/0", valid_out, d1, d3);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL areset_ready: got %b want 1", ready_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("asynchronous reset mid-stream");
  endtask

  task automatic test_back_to_back();
    cons_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data = 32'(i); sel = 2'(i % 4); valid = 1'b1;
      #4;
      checks++;
      if (ready_out !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready_out);
      end
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 4'(1 << (i % 4)) || data_of(i % 4) !== 32'(i)) begin
        errors++; $display("FAIL b2b_beat[%0d]: got valid=%b data=%h want %b/%h",
                           i, valid_out, data_of(i % 4), 4'(1 << (i % 4)), i);
      end
      $display("beat %0d -> out%0d", i, i % 4);
    end
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 4'b0000) begin
      errors++; $display("FAIL b2b_drain: got valid=%b want 0000", valid_out);
    end
  endtask

  task automatic test_round_robin();
    cons_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data = 32'h20 + 32'(i); sel = 2'd0; valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 4'(1 << (i % 4)) || data_of(i % 4) !== 32'h20 + 32'(i)) begin
        errors++; $display("FAIL rr_beat[%0d]: got valid=%b data=%h want %b/%h",
                           i, valid_out, data_of(i % 4), 4'(1 << (i % 4)), 32'h20 + 32'(i));
      end
      $display("rr beat %h -> out%0d", 32'h20 + 32'(i), i % 4);
    end
    // Pointer is now 1; fill output 1 while the rest keep draining.
    cons_ready = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = 32'h30 + 32'(i); valid = 1'b1;
      #4;
      checks++;
      if (ready_out !== 1'b1) begin
        errors++; $display("FAIL rr_fill_ready[%0d]: got %b want 1", i, ready_out);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data = 32'h34;
      #4;
      checks++;
      if (ready_out !== 1'b0) begin
        errors++; $display("FAIL rr_hol_ready[%0d]: got %b want 0", i, ready_out);
      end
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 4'b0010 || d1 !== 32'h30) begin
        errors++; $display("FAIL rr_hol_hold[%0d]: got valid=%b d1=%h want 0010/30", i, valid_out, d1);
      end
    end
    @(negedge clk);
    cons_ready = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 4'b0010 || d1 !== 32'h34) begin
      errors++; $display("FAIL rr_ptr_held: got valid=%b d1=%h want 0010/34", valid_out, d1);
    end
    @(negedge clk);
    valid = 1'b0;
    $display("rr head-of-line block on out1 released");
  endtask

  initial begin
    rst_n = 1'b0; data = '0; sel = 2'd0; valid = 1'b0; cons_ready = 4'b0000;
    test_reset();
`ifdef DEMUX_1_TO_4_RR_EN
    test_round_robin();
`else
    test_first_beat();
    test_stall();
    test_isolation();
    test_async_reset();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
